command_issuer: RTL and testbench
=================================

# command_issuer

Transmit end of the heater command interface. Holds the host-side setpoint and PID gain values and serialises them into 16-bit command words: 2-bit opcode in [15:14], 14-bit value in [13:0]. Words go over a valid/ready link to the command-processing block. The block sends only changed fields, refreshes all fields periodically, and pre-clamps the setpoint to the legal range so the receiver never has to saturate.

## Interface
- REFRESH_CYCLES, default 1000: idle cycles with nothing pending before all four fields are re-sent; 0 disables refresh.
- CLK  in  1  rising-edge clock
- RST  in  1  synchronous, active-high reset
- LOAD  in  1  capture strobe for SP_IN/KP_IN/KI_IN/KD_IN
- SP_IN  in  14  requested setpoint
- KP_IN  in  14  proportional gain
- KI_IN  in  14  integral gain
- KD_IN  in  14  derivative gain
- COMMAND  out  16  {opcode, value}
- CMD_VALID  out  1  COMMAND holds a word to transfer
- CMD_READY  in  1  receiver accepts the word this cycle
- BUSY  out  1  CMD_VALID, or any field pending
- CLAMPED  out  1  one-cycle pulse: the setpoint captured on the last LOAD was saturated

## Operation
- Opcodes: 00 setpoint, 01 proportional, 10 integral, 11 derivative. Field index equals opcode.
- Setpoint limits: SP_MIN = 14'd3520 (0x0DC0), SP_MAX = 14'd12800 (0x3200).
  - On LOAD, SP_IN < SP_MIN stores SP_MIN and SP_IN > SP_MAX stores SP_MAX; CLAMPED pulses in both cases.
  - Gains are stored unmodified.
- Registers: shadow[4], holding the latest captured values; sent[4], holding the last value handed off per field; pending[3:0].
- On LOAD, all shadows update. pending[i] is set when the new shadow[i] differs from sent[i]. It is cleared if the new value equals sent[i] and field i is not in flight.
- FSM has two states.
  - IDLE: if pending is non-zero, select the lowest pending index i. Drive COMMAND = {i, shadow[i]}, assert CMD_VALID, go to SEND.
  - SEND: COMMAND and CMD_VALID are held stable while CMD_READY = 0, including when a LOAD lands mid-transfer.
  - On handshake (CMD_VALID & CMD_READY): sent[i] takes the launched value, and pending[i] clears unless shadow[i] has changed since launch.
  - After the handshake, if any field is still pending, the next lowest index is presented on the following cycle with no bubble, staying in SEND. Otherwise drop CMD_VALID and return to IDLE.
- Refresh: a counter runs only in IDLE with pending = 0. It resets on any LOAD or transfer. When it reaches REFRESH_CYCLES-1, pending is forced to 4'b1111.
- Reset values:
  - COMMAND = 0, CMD_VALID = 0, CLAMPED = 0.
  - shadow[0] = sent[0] = SP_MIN; other shadows and sents = 0.
  - State IDLE, refresh counter 0.
  - pending = 4'b1111, so the receiver is initialised right after reset. BUSY is therefore 1 in the first cycle after reset is released.
- RST asserted mid-transfer aborts the word immediately: CMD_VALID = 0 after that edge.
- LOAD and a handshake on the same edge: the handshake commits the old launched value, and LOAD then re-evaluates pending against the updated sent.

## Timing
- LOAD sampled at edge k: shadows and CLAMPED update at edge k, and CMD_VALID rises after edge k+1 if the block was idle.
- Handshake at edge m with more pending: the next word is on COMMAND after edge m.
- Four back-to-back words with CMD_READY held at 1 take 4 cycles.
- BUSY is combinational: CMD_VALID | (pending != 0).

## Structure
- Shared package cmd_pkg holds the common constants, shared with the command-processing block so both ends cannot drift:
  - CMD_W = 16, VAL_W = 14
  - the four opcode constants
  - SP_MIN, SP_MAX
  - a state enum {IDLE, SEND}
- Single flat module; no sub-module is needed. The clamp is a package function.

## Test plan
- Reset release with CMD_READY = 1: words 0x0DC0, 0x4000, 0x8000, 0xC000 on consecutive cycles, then CMD_VALID = 0 and BUSY = 0.
- LOAD with SP_IN = 0x0D80 and gains unchanged: CLAMPED pulses, and the single word 0x0DC0 is not re-sent, because the clamped value equals sent[0]. Then LOAD SP_IN = 0x3FFF: CLAMPED pulses, word 0x3200.
- LOAD SP_IN = 0x1280, KD_IN = 0x2000 with CMD_READY = 0 for 5 cycles: COMMAND holds 0x1280 throughout; after READY, the word 0xE000 follows with no gap.
- A mid-transfer LOAD changing the in-flight setpoint from 0x1280 to 0x1300: 0x1280 completes, then 0x1300 is sent.
- REFRESH_CYCLES = 8, idle with nothing pending: after 8 idle cycles all four current values are re-sent in opcode order.
- RST asserted while CMD_VALID = 1: CMD_VALID = 0 next cycle, then the full reset sequence from the first scenario.

Source files
------------

// File: rtl/cmd_pkg.sv
// Constants shared by both ends of the heater command link so the
// transmitter and the command-processing block cannot drift apart.
package cmd_pkg;

  localparam int CMD_W = 16;
  localparam int VAL_W = 14;

  localparam logic [1:0] OP_SP = 2'b00;
  localparam logic [1:0] OP_KP = 2'b01;
  localparam logic [1:0] OP_KI = 2'b10;
  localparam logic [1:0] OP_KD = 2'b11;

  localparam logic [VAL_W-1:0] SP_MIN = 14'd3520;
  localparam logic [VAL_W-1:0] SP_MAX = 14'd12800;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  function automatic logic [VAL_W-1:0] clamp_sp(input logic [VAL_W-1:0] value);
    if (value < SP_MIN) return SP_MIN;
    if (value > SP_MAX) return SP_MAX;
    return value;
  endfunction

  // Field index doubles as opcode; lower indices win.
  function automatic logic [1:0] lowest_idx(input logic [3:0] pend);
    if (pend[0]) return OP_SP;
    if (pend[1]) return OP_KP;
    if (pend[2]) return OP_KI;
    return OP_KD;
  endfunction

endpackage

// File: rtl/command_issuer.sv
// Heater command transmitter: captures setpoint and PID gains, sends changed
// fields as {opcode, value} words over valid/ready, and refreshes them when idle.
//
//   state | meaning
//   IDLE  | no word on the link; launches lowest pending field, counts refresh
//   SEND  | COMMAND/CMD_VALID held until handshake; chains pending words
module command_issuer
  import cmd_pkg::*;
#(
  parameter int REFRESH_CYCLES = 1000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LOAD,
  input  logic [VAL_W-1:0] SP_IN,
  input  logic [VAL_W-1:0] KP_IN,
  input  logic [VAL_W-1:0] KI_IN,
  input  logic [VAL_W-1:0] KD_IN,
  output logic [CMD_W-1:0] COMMAND,
  output logic             CMD_VALID,
  input  logic             CMD_READY,
  output logic             BUSY,
  output logic             CLAMPED
);

  localparam int CNT_W = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] REF_TC = CNT_W'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);

  state_t           state, state_nxt;
  logic [VAL_W-1:0] shadow [4];
  logic [VAL_W-1:0] shadow_nxt [4];
  logic [VAL_W-1:0] sent [4];
  logic [VAL_W-1:0] sent_nxt [4];
  logic [VAL_W-1:0] load_val [4];
  logic [3:0]       pending, pending_nxt;
  logic [CNT_W-1:0] ref_cnt, ref_cnt_nxt;
  logic [CMD_W-1:0] command_nxt;
  logic             cmd_valid_nxt;
  logic             clamped_nxt;
  logic             handshake;
  logic             launch;
  logic [1:0]       launch_idx;
  logic [1:0]       cur_idx;
  logic [VAL_W-1:0] sp_clamped;

  assign sp_clamped  = clamp_sp(SP_IN);
  assign load_val[0] = sp_clamped;
  assign load_val[1] = KP_IN;
  assign load_val[2] = KI_IN;
  assign load_val[3] = KD_IN;

  assign handshake = CMD_VALID & CMD_READY;
  assign cur_idx   = COMMAND[CMD_W-1:VAL_W];
  assign BUSY      = CMD_VALID | (pending != 4'b0000);

  always_comb begin
    state_nxt     = state;
    shadow_nxt    = shadow;
    sent_nxt      = sent;
    pending_nxt   = pending;
    ref_cnt_nxt   = '0;
    command_nxt   = COMMAND;
    cmd_valid_nxt = CMD_VALID;
    clamped_nxt   = LOAD & (sp_clamped != SP_IN);
    launch        = 1'b0;
    launch_idx    = 2'd0;

    // Commit the launched value; keep the field pending if it moved in flight.
    if (handshake) begin
      sent_nxt[cur_idx]    = COMMAND[VAL_W-1:0];
      pending_nxt[cur_idx] = (shadow[cur_idx] != COMMAND[VAL_W-1:0]);
    end

    case (state)
      IDLE: launch = |pending;
      SEND: begin
        if (handshake) begin
          launch = |pending_nxt;
          if (!launch) begin
            state_nxt     = IDLE;
            cmd_valid_nxt = 1'b0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (launch) begin
      launch_idx    = lowest_idx(pending_nxt);
      command_nxt   = {launch_idx, shadow[launch_idx]};
      cmd_valid_nxt = 1'b1;
      state_nxt     = SEND;
    end

    // LOAD is judged against sent after this edge's handshake commit.
    if (LOAD) begin
      for (int i = 0; i < 4; i++) begin
        shadow_nxt[i] = load_val[i];
        if (load_val[i] != sent_nxt[i]) begin
          pending_nxt[i] = 1'b1;
        end else if (!(cmd_valid_nxt && (command_nxt[CMD_W-1:VAL_W] == 2'(i)))) begin
          pending_nxt[i] = 1'b0;
        end
      end
    end else if ((REFRESH_CYCLES != 0) && (state == IDLE) && (pending == 4'b0000)) begin
      if (ref_cnt == REF_TC) begin
        pending_nxt = 4'b1111;
      end else begin
        ref_cnt_nxt = ref_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      pending   <= 4'b1111;
      ref_cnt   <= '0;
      COMMAND   <= '0;
      CMD_VALID <= 1'b0;
      CLAMPED   <= 1'b0;
      shadow[0] <= SP_MIN;
      sent[0]   <= SP_MIN;
      for (int i = 1; i < 4; i++) begin
        shadow[i] <= '0;
        sent[i]   <= '0;
      end
    end else begin
      state     <= state_nxt;
      pending   <= pending_nxt;
      ref_cnt   <= ref_cnt_nxt;
      COMMAND   <= command_nxt;
      CMD_VALID <= cmd_valid_nxt;
      CLAMPED   <= clamped_nxt;
      shadow    <= shadow_nxt;
      sent      <= sent_nxt;
    end
  end

endmodule

// File: tb/tb_command_issuer.sv
// Scoreboard bench for command_issuer: expected words are queued with the
// stimulus and matched against words observed on the valid/ready link.
module tb_command_issuer;
  import cmd_pkg::*;

  logic        clk;
  logic        rst;
  logic        load;
  logic [13:0] sp_in, kp_in, ki_in, kd_in;
  logic [15:0] command;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        busy;
  logic        clamped;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_obs_cyc = 0;

  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  int          obs_cyc[$];

  command_issuer #(.REFRESH_CYCLES(8)) dut (
    .CLK(clk), .RST(rst), .LOAD(load),
    .SP_IN(sp_in), .KP_IN(kp_in), .KI_IN(ki_in), .KD_IN(kd_in),
    .COMMAND(command), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
    .BUSY(busy), .CLAMPED(clamped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change just after posedge, so a negedge sample sees the next edge's handshake.
  always @(negedge clk) begin
    if (cmd_valid && cmd_ready && !rst) begin
      obs_q.push_back(command);
      obs_cyc.push_back(cyc);
      last_obs_cyc = cyc;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_load(input logic [13:0] sp, input logic [13:0] kp,
                            input logic [13:0] ki, input logic [13:0] kd);
    sp_in = sp; kp_in = kp; ki_in = ki; kd_in = kd;
    load = 1'b1;
    tick(1);
    load = 1'b0;
  endtask

  task automatic collect(input int n, input int budget, output bit ok);
    int k = 0;
    while (obs_q.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    ok = (obs_q.size() >= n);
  endtask

  task automatic test_reset();
    bit ok;
    logic [15:0] w, e;
    int c, c0;
    rst = 1'b1; load = 1'b0; cmd_ready = 1'b1;
    tick(2);
    n_checks++; if (cmd_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", cmd_valid); else n_pass++;
    n_checks++; if (command !== 16'h0000) $display("FAIL rst_command got %h want 0000", command); else n_pass++;
    n_checks++; if (clamped !== 1'b0) $display("FAIL rst_clamped got %b want 0", clamped); else n_pass++;
    obs_q.delete(); obs_cyc.delete(); exp_q.delete();
    exp_q.push_back(16'h0DC0); exp_q.push_back(16'h4000);
    exp_q.push_back(16'h8000); exp_q.push_back(16'hC000);
    rst = 1'b0;
    n_checks++; if (busy !== 1'b1) $display("FAIL rst_busy got %b want 1", busy); else n_pass++;
    collect(4, 20, ok);
    n_checks++; if (!ok) $display("FAIL rst_seq_timeout got %0d words want 4", obs_q.size()); else n_pass++;
    c0 = 0;
    for (int i = 0; i < 4 && ok; i++) begin
      w = obs_q.pop_front(); c = obs_cyc.pop_front(); e = exp_q.pop_front();
      if (i == 0) c0 = c;
      n_checks++; if (w !== e) $display("FAIL rst_word%0d got %h want %h", i, w, e); else n_pass++;
      if (i == 3) begin
        n_checks++; if (c - c0 != 3) $display("FAIL rst_b2b got %0d cycles want 3", c - c0); else n_pass++;
      end
    end
    n_checks++; if (cmd_valid !== 1'b0) $display("FAIL rst_done_valid got %b want 0", cmd_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_done_busy got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_clamp();
    bit ok;
    logic [15:0] w, e;
    cmd_ready = 1'b1;
    apply_load(14'h0D80, 14'h0000, 14'h0000, 14'h0000);
    n_checks++; if (clamped !== 1'b1) $display("FAIL clamp_lo_pulse got %b want 1", clamped); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL clamp_lo_busy got %b want 0", busy); else n_pass++;
    tick(1);
    n_checks++; if (clamped !== 1'b0) $display("FAIL clamp_lo_end got %b want 0", clamped); else n_pass++;
    tick(3);
    n_checks++; if (obs_q.size() != 0) $display("FAIL clamp_lo_resend got %0d words want 0", obs_q.size()); else n_pass++;
    exp_q.push_back(16'h3200);
    apply_load(14'h3FFF, 14'h0000, 14'h0000, 14'h0000);
    n_checks++; if (clamped !== 1'b1) $display("FAIL clamp_hi_pulse got %b want 1", clamped); else n_pass++;
    collect(1, 10, ok);
    n_checks++; if (!ok) $display("FAIL clamp_hi_timeout got %0d words want 1", obs_q.size()); else n_pass++;
    if (ok) begin
      w = obs_q.pop_front(); void'(obs_cyc.pop_front()); e = exp_q.pop_front();
      n_checks++; if (w !== e) $display("FAIL clamp_hi_word got %h want %h", w, e); else n_pass++;
    end
  endtask

  task automatic test_hold();
    bit ok;
    logic [15:0] w, e;
    int c, c0;
    cmd_ready = 1'b0;
    apply_load(14'h1280, 14'h0000, 14'h0000, 14'h2000);
    n_checks++; if (clamped !== 1'b0) $display("FAIL hold_clamped got %b want 0", clamped); else n_pass++;
    tick(1);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (cmd_valid !== 1'b1 || command !== 16'h1280)
        $display("FAIL hold_cycle%0d got valid=%b cmd=%h want valid=1 cmd=1280", i, cmd_valid, command);
      else n_pass++;
      tick(1);
    end
    exp_q.push_back(16'h1280); exp_q.push_back(16'hE000);
    cmd_ready = 1'b1;
    collect(2, 10, ok);
    n_checks++; if (!ok) $display("FAIL hold_timeout got %0d words want 2", obs_q.size()); else n_pass++;
    c0 = 0;
    for (int i = 0; i < 2 && ok; i++) begin
      w = obs_q.pop_front(); c = obs_cyc.pop_front(); e = exp_q.pop_front();
      if (i == 0) c0 = c;
      n_checks++; if (w !== e) $display("FAIL hold_word%0d got %h want %h", i, w, e); else n_pass++;
      if (i == 1) begin
        n_checks++; if (c - c0 != 1) $display("FAIL hold_gap got %0d cycles want 1", c - c0); else n_pass++;
      end
    end
  endtask

  task automatic test_midload();
    bit ok;
    logic [15:0] w, e;
    cmd_ready = 1'b1;
    exp_q.push_back(16'h0E00);
    apply_load(14'h0E00, 14'h0000, 14'h0000, 14'h2000);
    collect(1, 10, ok);
    n_checks++; if (!ok) $display("FAIL mid_pre_timeout got %0d words want 1", obs_q.size()); else n_pass++;
    if (ok) begin
      w = obs_q.pop_front(); void'(obs_cyc.pop_front()); e = exp_q.pop_front();
      n_checks++; if (w !== e) $display("FAIL mid_pre_word got %h want %h", w, e); else n_pass++;
    end
    cmd_ready = 1'b0;
    apply_load(14'h1280, 14'h0000, 14'h0000, 14'h2000);
    tick(2);
    apply_load(14'h1300, 14'h0000, 14'h0000, 14'h2000);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (cmd_valid !== 1'b1 || command !== 16'h1280)
        $display("FAIL mid_hold%0d got valid=%b cmd=%h want valid=1 cmd=1280", i, cmd_valid, command);
      else n_pass++;
      tick(1);
    end
    exp_q.push_back(16'h1280); exp_q.push_back(16'h1300);
    cmd_ready = 1'b1;
    collect(2, 10, ok);
    n_checks++; if (!ok) $display("FAIL mid_timeout got %0d words want 2", obs_q.size()); else n_pass++;
    for (int i = 0; i < 2 && ok; i++) begin
      w = obs_q.pop_front(); void'(obs_cyc.pop_front()); e = exp_q.pop_front();
      n_checks++; if (w !== e) $display("FAIL mid_word%0d got %h want %h", i, w, e); else n_pass++;
    end
  endtask

  task automatic test_refresh();
    bit ok;
    logic [15:0] w, e;
    int c, c0, ref0;
    ref0 = last_obs_cyc;
    cmd_ready = 1'b1;
    exp_q.push_back(16'h1300); exp_q.push_back(16'h4000);
    exp_q.push_back(16'h8000); exp_q.push_back(16'hE000);
    collect(4, 40, ok);
    n_checks++; if (!ok) $display("FAIL refresh_timeout got %0d words want 4", obs_q.size()); else n_pass++;
    c0 = 0;
    for (int i = 0; i < 4 && ok; i++) begin
      w = obs_q.pop_front(); c = obs_cyc.pop_front(); e = exp_q.pop_front();
      if (i == 0) begin
        c0 = c;
        n_checks++; if (c - ref0 != 10) $display("FAIL refresh_delay got %0d cycles want 10", c - ref0); else n_pass++;
      end
      n_checks++; if (w !== e) $display("FAIL refresh_word%0d got %h want %h", i, w, e); else n_pass++;
      if (i == 3) begin
        n_checks++; if (c - c0 != 3) $display("FAIL refresh_b2b got %0d cycles want 3", c - c0); else n_pass++;
      end
    end
  endtask

  task automatic test_same_edge();
    bit ok;
    logic [15:0] w, e;
    cmd_ready = 1'b0;
    apply_load(14'h1300, 14'h0055, 14'h0000, 14'h2000);
    tick(1);
    n_checks++;
    if (cmd_valid !== 1'b1 || command !== 16'h4055)
      $display("FAIL same_launch got valid=%b cmd=%h want valid=1 cmd=4055", cmd_valid, command);
    else n_pass++;
    exp_q.push_back(16'h4055); exp_q.push_back(16'h4000);
    cmd_ready = 1'b1;
    apply_load(14'h1300, 14'h0000, 14'h0000, 14'h2000);
    collect(2, 10, ok);
    n_checks++; if (!ok) $display("FAIL same_timeout got %0d words want 2", obs_q.size()); else n_pass++;
    for (int i = 0; i < 2 && ok; i++) begin
      w = obs_q.pop_front(); void'(obs_cyc.pop_front()); e = exp_q.pop_front();
      n_checks++; if (w !== e) $display("FAIL same_word%0d got %h want %h", i, w, e); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    cmd_ready = 1'b0;
    apply_load(14'h1300, 14'h0123, 14'h0000, 14'h2000);
    tick(1);
    n_checks++;
    if (cmd_valid !== 1'b1 || command !== 16'h4123)
      $display("FAIL rmid_launch got valid=%b cmd=%h want valid=1 cmd=4123", cmd_valid, command);
    else n_pass++;
    rst = 1'b1;
    tick(1);
    n_checks++; if (cmd_valid !== 1'b0) $display("FAIL rmid_abort got %b want 0", cmd_valid); else n_pass++;
    test_reset();
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; cmd_ready = 1'b1;
    sp_in = '0; kp_in = '0; ki_in = '0; kd_in = '0;
    test_reset();
    test_clamp();
    test_hold();
    test_midload();
    test_refresh();
    test_same_edge();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
